// File: rtl/ddr_note_scroller.sv
// DDR note scroller: holds falling notes per lane, scrolls them each frame, judges hits, draws pixels.
// Optional DDR_TARGET_BAR_EN draws a grey outline around the target zone in every lane.
module ddr_note_scroller #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned NOTE_H   = 32,
  parameter int unsigned LANE_X0  = 192,
  parameter int unsigned LANE_W   = 64,
  parameter int unsigned TARGET_Y = 400,
  parameter int unsigned HIT_WIN  = 24
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  input  logic [3:0]  hit_btn,
  output logic [3:0]  hit_ok,
  output logic [3:0]  hit_bad,
  output logic [3:0]  miss,
  output logic [11:0] rgb
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CW    = 10;
  localparam int unsigned SW    = 11;
  localparam int unsigned LWB   = $clog2(LANE_W);

  localparam logic [SW-1:0] SCR_H  = SW'(480);
  localparam logic [SW-1:0] HIT_LO = SW'(TARGET_Y - HIT_WIN);
  localparam logic [SW-1:0] HIT_HI = SW'(TARGET_Y + HIT_WIN);
  localparam logic [SW-1:0] SPD    = SW'(SPEED);
  localparam logic [SW-1:0] NH     = SW'(NOTE_H);
  localparam logic [SW-1:0] X_LO   = SW'(LANE_X0);
  localparam logic [SW-1:0] X_HI   = SW'(LANE_X0 + LANES * LANE_W);
  localparam logic [CW-1:0] FRAME_Y = CW'(480);

  logic [SLOTS-1:0] act_q [LANES];
  logic [SLOTS-1:0] act_d [LANES];
  logic [CW-1:0]    top_q [LANES][SLOTS];
  logic [CW-1:0]    top_d [LANES][SLOTS];
  logic [3:0]       hit_ok_q, hit_ok_d;
  logic [3:0]       hit_bad_q, hit_bad_d;
  logic [3:0]       miss_q, miss_d;
  logic [11:0]      rgb_q, rgb_d;

  logic             frame_tick_c;
  logic             spawn_fire_c;
  logic [1:0]       lane_c;
  logic             in_lanes_c;
  logic             lit_c;
  logic [11:0]      pix_c;

  assign frame_tick_c = p_tick & (x == '0) & (y == FRAME_Y);
  assign spawn_ready  = ~&act_q[spawn_lane];
  assign spawn_fire_c = spawn_valid & spawn_ready;

  // Slot update: hit beats frame advance; spawns only land in slots free before this edge.
  always_comb begin
    logic          hit_found;
    logic          spawn_found;
    logic [SW-1:0] sum;
    logic          in_win;
    act_d       = act_q;
    top_d       = top_q;
    hit_ok_d    = '0;
    hit_bad_d   = '0;
    miss_d      = '0;
    hit_found   = 1'b0;
    spawn_found = 1'b0;
    sum         = '0;
    in_win      = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      hit_found   = 1'b0;
      spawn_found = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        sum    = {1'b0, top_q[l][s]} + SPD;
        in_win = act_q[l][s] && ({1'b0, top_q[l][s]} >= HIT_LO) && ({1'b0, top_q[l][s]} <= HIT_HI);
        if (hit_btn[l] && in_win && !hit_found) begin
          hit_found    = 1'b1;
          act_d[l][s]  = 1'b0;
        end else if (act_q[l][s] && frame_tick_c) begin
          if (sum >= SCR_H) begin
            act_d[l][s] = 1'b0;
            miss_d[l]   = 1'b1;
          end else begin
            top_d[l][s] = sum[CW-1:0];
          end
        end else if (!act_q[l][s] && spawn_fire_c && (spawn_lane == 2'(l)) && !spawn_found) begin
          spawn_found  = 1'b1;
          act_d[l][s]  = 1'b1;
          top_d[l][s]  = '0;
        end
      end
      hit_ok_d[l]  = hit_btn[l] & hit_found;
      hit_bad_d[l] = hit_btn[l] & ~hit_found;
    end
  end

  // Pixel colour for the current counters.
  always_comb begin
    lane_c     = 2'((x - CW'(LANE_X0)) >> LWB);
    in_lanes_c = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI);
    lit_c      = 1'b0;
    pix_c      = 12'h000;
    for (int s = 0; s < SLOTS; s++) begin
      if (act_q[lane_c][s] && ({1'b0, y} >= {1'b0, top_q[lane_c][s]}) &&
          ({1'b0, y} < ({1'b0, top_q[lane_c][s]} + NH))) begin
        lit_c = 1'b1;
      end
    end
    if (in_lanes_c) begin
      if (lit_c) begin
        case (lane_c)
          2'd0:    pix_c = 12'hA0F;
          2'd1:    pix_c = 12'h08F;
          2'd2:    pix_c = 12'h0F4;
          default: pix_c = 12'hF20;
        endcase
      end
`ifdef DDR_TARGET_BAR_EN
      else if (({1'b0, y} >= SW'(TARGET_Y)) && ({1'b0, y} < SW'(TARGET_Y + NOTE_H)) &&
               ((LWB'(x - CW'(LANE_X0)) < LWB'(2)) ||
                (LWB'(x - CW'(LANE_X0)) >= LWB'(LANE_W - 2)) ||
                (CW'(y - CW'(TARGET_Y)) < CW'(2)) ||
                (CW'(y - CW'(TARGET_Y)) >= CW'(NOTE_H - 2)))) begin
        pix_c = 12'h888;
      end
`endif
    end
    rgb_d = rgb_q;
    if (p_tick) begin
      rgb_d = video_on ? pix_c : 12'h000;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < LANES; l++) begin
        act_q[l] <= '0;
        for (int s = 0; s < SLOTS; s++) begin
          top_q[l][s] <= '0;
        end
      end
      hit_ok_q  <= '0;
      hit_bad_q <= '0;
      miss_q    <= '0;
      rgb_q     <= '0;
    end else begin
      act_q     <= act_d;
      top_q     <= top_d;
      hit_ok_q  <= hit_ok_d;
      hit_bad_q <= hit_bad_d;
      miss_q    <= miss_d;
      rgb_q     <= rgb_d;
    end
  end

  assign hit_ok  = hit_ok_q;
  assign hit_bad = hit_bad_q;
  assign miss    = miss_q;
  assign rgb     = rgb_q;

endmodule

// File: tb/tb_ddr_note_scroller.sv
// Directed bench for ddr_note_scroller: frames are injected as single x=0,y=480 pixel ticks.
module tb_ddr_note_scroller;

  logic        clk;
  logic        rst_n;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        spawn_valid;
  logic [1:0]  spawn_lane;
  logic        spawn_ready;
  logic [3:0]  hit_btn;
  logic [3:0]  hit_ok;
  logic [3:0]  hit_bad;
  logic [3:0]  miss;
  logic [11:0] rgb;

  int checks = 0;
  int errors = 0;
  logic [3:0] miss_acc;

  typedef struct {
    logic        pt;
    logic        von;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] exp_rgb;
  } rvec_t;

  rvec_t rtab [12];

  ddr_note_scroller dut (
    .clk_100MHz (clk),
    .reset_n    (rst_n),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .spawn_valid(spawn_valid),
    .spawn_lane (spawn_lane),
    .spawn_ready(spawn_ready),
    .hit_btn    (hit_btn),
    .hit_ok     (hit_ok),
    .hit_bad    (hit_bad),
    .miss       (miss),
    .rgb        (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk(name, 12'(act), 12'(exp));
  endtask

  task automatic chk_ready(input string name, input logic [1:0] lane, input logic exp);
    spawn_lane = lane;
    #1;
    chk(name, 12'(spawn_ready), 12'(exp));
  endtask

  task automatic idle_inputs();
    p_tick   = 1'b0;
    video_on = 1'b0;
    x        = 10'd700;
    y        = 10'd500;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      x = 10'd0; y = 10'd480; p_tick = 1'b1; video_on = 1'b0;
      step();
      miss_acc = miss_acc | miss;
      idle_inputs();
    end
  endtask

  task automatic spawn(input logic [1:0] lane);
    spawn_valid = 1'b1;
    spawn_lane  = lane;
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic press(input int lane);
    hit_btn = 4'(1 << lane);
    step();
    hit_btn = 4'b0000;
  endtask

  task automatic render(input string name, input logic [9:0] px, input logic [9:0] py,
                        input logic [11:0] exp);
    p_tick = 1'b1; video_on = 1'b1; x = px; y = py;
    step();
    idle_inputs();
    chk(name, rgb, exp);
  endtask

  initial begin
    rtab[0]  = '{1'b1, 1'b1, 10'd320, 10'd410, 12'h0F4};
    rtab[1]  = '{1'b1, 1'b1, 10'd319, 10'd410, 12'h000};
    rtab[2]  = '{1'b1, 1'b1, 10'd383, 10'd400, 12'h0F4};
    rtab[3]  = '{1'b1, 1'b1, 10'd384, 10'd400, 12'h000};
    rtab[4]  = '{1'b1, 1'b1, 10'd320, 10'd431, 12'h0F4};
    rtab[5]  = '{1'b1, 1'b1, 10'd320, 10'd432, 12'h000};
    rtab[6]  = '{1'b1, 1'b1, 10'd320, 10'd399, 12'h000};
    rtab[7]  = '{1'b1, 1'b0, 10'd320, 10'd410, 12'h000};
    rtab[8]  = '{1'b1, 1'b1, 10'd320, 10'd410, 12'h0F4};
    rtab[9]  = '{1'b0, 1'b1, 10'd319, 10'd410, 12'h0F4};
    rtab[10] = '{1'b1, 1'b1, 10'd191, 10'd410, 12'h000};
    rtab[11] = '{1'b1, 1'b1, 10'd448, 10'd410, 12'h000};

    rst_n = 1'b0; spawn_valid = 1'b0; spawn_lane = 2'd0; hit_btn = 4'b0000;
    miss_acc = 4'b0000;
    idle_inputs();
    step(); step();

    // Reset state
    chk("rst_rgb", rgb, 12'h000);
    chk4("rst_hit_ok", hit_ok, 4'b0000);
    chk4("rst_hit_bad", hit_bad, 4'b0000);
    chk4("rst_miss", miss, 4'b0000);
    for (int l = 0; l < 4; l++) chk_ready($sformatf("rst_ready%0d", l), 2'(l), 1'b1);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 12; i++)
      render($sformatf("empty_px%0d", i), 10'(192 + i * 21), 10'(i * 40), 12'h000);

    // Lane 2 note scrolled to the target row, then rendered from the table
    spawn(2'd2);
    frames(100);
    for (int i = 0; i < 12; i++) begin
      p_tick = rtab[i].pt; video_on = rtab[i].von; x = rtab[i].px; y = rtab[i].py;
      step();
      idle_inputs();
      chk($sformatf("render%0d", i), rgb, rtab[i].exp_rgb);
    end
    press(2);
    chk4("l2_hit_ok", hit_ok, 4'b0100);
    chk4("l2_hit_bad", hit_bad, 4'b0000);
    step();
    chk4("l2_hit_ok_pulse", hit_ok, 4'b0000);

    // Lane 0 hit at 400, then a second press finds nothing
    spawn(2'd0);
    frames(100);
    press(0);
    chk4("l0_hit_ok", hit_ok, 4'b0001);
    step();
    chk4("l0_hit_ok_clr", hit_ok, 4'b0000);
    render("l0_gone", 10'd192, 10'd410, 12'h000);
    press(0);
    chk4("l0_bad", hit_bad, 4'b0001);
    chk4("l0_bad_ok", hit_ok, 4'b0000);

    // Lower window edge: 372 is outside, 376 inside
    spawn(2'd0);
    frames(93);
    press(0);
    chk4("lo372_bad", hit_bad, 4'b0001);
    chk4("lo372_ok", hit_ok, 4'b0000);
    render("lo372_kept", 10'd200, 10'd372, 12'hA0F);
    frames(1);
    press(0);
    chk4("lo376_ok", hit_ok, 4'b0001);

    // Upper window edge: 424 inside, 428 outside and later missed
    spawn(2'd0);
    frames(106);
    press(0);
    chk4("hi424_ok", hit_ok, 4'b0001);
    spawn(2'd0);
    frames(107);
    press(0);
    chk4("hi428_bad", hit_bad, 4'b0001);
    miss_acc = 4'b0000;
    frames(12);
    chk4("hi428_no_early_miss", miss_acc, 4'b0000);
    frames(1);
    chk4("hi428_miss", miss, 4'b0001);

    // Lane 1 fill; fifth request ignored
    for (int i = 0; i < 4; i++) spawn(2'd1);
    chk_ready("l1_full", 2'd1, 1'b0);
    chk_ready("l0_free", 2'd0, 1'b1);
    spawn(2'd1);
    chk_ready("l1_still_full", 2'd1, 1'b0);
    render("l1_top0", 10'd256, 10'd0, 12'h08F);
    render("l1_row32", 10'd256, 10'd32, 12'h000);
    miss_acc = 4'b0000;
    frames(119);
    chk4("l1_no_early_miss", miss_acc, 4'b0000);
    frames(1);
    chk4("l1_miss", miss, 4'b0010);
    chk_ready("l1_freed", 2'd1, 1'b1);

    // Lane 3 fill, all notes fall off together
    for (int i = 0; i < 4; i++) spawn(2'd3);
    chk_ready("l3_full", 2'd3, 1'b0);
    miss_acc = 4'b0000;
    frames(119);
    chk4("l3_no_early_miss", miss_acc, 4'b0000);
    frames(1);
    chk4("l3_miss", miss, 4'b1000);
    step();
    chk4("l3_miss_pulse", miss, 4'b0000);
    chk_ready("l3_freed", 2'd3, 1'b1);

    // Hit and frame tick in the same cycle at top=376
    spawn(2'd0);
    frames(94);
    x = 10'd0; y = 10'd480; p_tick = 1'b1; hit_btn = 4'b0001;
    step();
    hit_btn = 4'b0000;
    idle_inputs();
    chk4("sim_hit_ok", hit_ok, 4'b0001);
    chk4("sim_no_miss", miss, 4'b0000);
    render("sim_cleared", 10'd200, 10'd380, 12'h000);
    miss_acc = 4'b0000;
    frames(30);
    chk4("sim_never_miss", miss_acc, 4'b0000);

    // Reset mid-frame clears notes and rgb immediately
    spawn(2'd0);
    frames(10);
    render("pre_rst_lit", 10'd192, 10'd40, 12'hA0F);
    rst_n = 1'b0;
    #1;
    chk("midrst_rgb", rgb, 12'h000);
    chk_ready("midrst_ready", 2'd0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    render("post_rst_dark", 10'd192, 10'd40, 12'h000);

    // Spawn on the frame tick: new note stays at top=0
    spawn_valid = 1'b1; spawn_lane = 2'd2;
    x = 10'd0; y = 10'd480; p_tick = 1'b1;
    step();
    spawn_valid = 1'b0;
    idle_inputs();
    render("spawn_tick_row0", 10'd320, 10'd0, 12'h0F4);
    render("spawn_tick_row32", 10'd320, 10'd32, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
